// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
//   N_REQ   : number of requesters sharing the mux
//   IDX_W   : width of a requester index / mux select
//   state_e : arbiter state encoding (ST_IDLE, ST_BUSY)
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/muxi4_1.sv
// Existing 4:1 two-bit multiplexer.
// Ports:
//   i0..i3 : data inputs, 2 bits each
//   s      : select, 2 bits
//   o      : selected input, 2 bits
module muxi4_1 (
    input  logic [1:0] i0,
    input  logic [1:0] i1,
    input  logic [1:0] i2,
    input  logic [1:0] i3,
    input  logic [1:0] s,
    output logic [1:0] o
);

    always_comb begin
        o = i0;
        unique case (s)
            2'd0: o = i0;
            2'd1: o = i1;
            2'd2: o = i2;
            2'd3: o = i3;
            default: o = i0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing muxi4_1 between four requesters and presenting
// the selected word to one consumer over a valid/ready handshake.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req[3:0]      : requester k has a word on ik
//   i0..i3        : requester data (W bits, held while req is high)
//   gnt[3:0]      : one-hot pulse in the cycle the selected word is accepted
//   sel[1:0]      : registered mux select (currently granted index)
//   out_valid     : out_data holds a word for the consumer
//   out_data      : mux output for sel (combinational)
//   out_ready     : consumer accepts when out_valid && out_ready
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned W = 2  // must match muxi4_1; only 2 is supported
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [W-1:0]        i0,
    input  logic [W-1:0]        i1,
    input  logic [W-1:0]        i2,
    input  logic [W-1:0]        i3,
    output logic [N_REQ-1:0]    gnt,
    output logic [IDX_W-1:0]    sel,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    input  logic                out_ready
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_inc;
    logic [N_REQ-1:0]   sel_oh;
    logic [N_REQ-1:0]   req_masked;

    // First set bit of r searching from index p upward, wrapping 3 -> 0.
    // Rotate so p lands at bit 0, priority-encode the lowest bit, un-rotate.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [N_REQ-1:0] rot;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] off;
        rot = '0;
        off = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx    = IDX_W'(k) + p;
            rot[k] = r[idx];
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
        return off + p;
    endfunction

    assign sel_inc    = sel_q + IDX_W'(1);
    assign sel_oh     = N_REQ'(1) << sel_q;
    assign req_masked = req & ~sel_oh;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        gnt       = '0;
        out_valid = (state_q == ST_BUSY);

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    sel_d   = rr_pick(req, ptr_q);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (out_ready) begin
                    // Accept wins over a simultaneous withdraw.
                    gnt   = sel_oh;
                    ptr_d = sel_inc;
                    if (|req_masked) begin
                        sel_d = rr_pick(req_masked, sel_inc);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!req[sel_q]) begin
                    // Withdraw: abandon the word, keep ptr.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) gnt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel = sel_q;

    muxi4_1 u_mux (
        .i0 (i0),
        .i1 (i1),
        .i2 (i2),
        .i3 (i3),
        .s  (sel_q),
        .o  (out_data)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] i0, i1, i2, i3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_ready;

    int n_checks = 0;
    int n_errors = 0;
    bit done = 0;

    // Expected accepted transfers: {gnt, data}
    logic [5:0] exp_q[$];

    mux4_rr_arbiter #(.W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .i0        (i0),
        .i1        (i1),
        .i2        (i2),
        .i3        (i3),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic chk_busy(input string name, input logic [1:0] s);
        @(negedge clk);
        chk({name, "_valid"}, 8'(out_valid), 8'd1);
        chk({name, "_sel"}, 8'(sel), 8'(s));
    endtask

    task automatic chk_idle(input string name);
        @(negedge clk);
        chk({name, "_valid"}, 8'(out_valid), 8'd0);
        chk({name, "_gnt"}, 8'(gnt), 8'd0);
    endtask

    // Monitor: every grant pulse must match the next expected transfer.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (!done && gnt != 4'b0000) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_gnt: got gnt=%b data=%b, none expected at %0t",
                             gnt, out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({gnt, out_data} !== e) begin
                        n_errors++;
                        $display("FAIL xfer: got gnt=%b data=%b expected gnt=%b data=%b at %0t",
                                 gnt, out_data, e[5:2], e[1:0], $time);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1; req = 4'b1111; out_ready = 0;
        i0 = 2'b00; i1 = 2'b01; i2 = 2'b10; i3 = 2'b11;

        // Reset, two cycles with all requests pending
        cyc();
        @(negedge clk);
        chk("rst_valid", 8'(out_valid), 8'd0);
        chk("rst_gnt", 8'(gnt), 8'd0);
        chk("rst_sel", 8'(sel), 8'd0);
        cyc(); rst = 0;
        chk_idle("rst_rel");
        cyc();
        chk_busy("first", 2'd0);
        chk("first_gnt", 8'(gnt), 8'd0);

        // Full rotation back-to-back
        cyc(); out_ready = 1;
        push(4'b0001, 2'b00); push(4'b0010, 2'b01); push(4'b0100, 2'b10);
        push(4'b1000, 2'b11); push(4'b0001, 2'b00);
        repeat (4) cyc();

        // Stall with sel=1, then accept
        cyc(); out_ready = 0; req = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc();
            chk_busy("stall", 2'd1);
            chk("stall_data", 8'(out_data), 8'h01);
            chk("stall_gnt", 8'(gnt), 8'd0);
        end
        cyc(); out_ready = 1; push(4'b0010, 2'b01);
        cyc(); out_ready = 0;
        chk_busy("after_stall", 2'd2);

        // Accept 2 alone, then 3 alone -> ptr wraps to 0
        cyc(); out_ready = 1; req = 4'b0100; push(4'b0100, 2'b10);
        cyc(); out_ready = 0; req = 4'b1000;
        chk_idle("idle_a");
        cyc(); out_ready = 1; push(4'b1000, 2'b11);
        chk_busy("lone3", 2'd3);
        cyc(); out_ready = 0; req = 4'b1001;
        chk_idle("idle_b");
        // Wrap/fairness: requester 0 before 3
        cyc(); out_ready = 1; push(4'b0001, 2'b00); push(4'b1000, 2'b11);
        chk_busy("wrap0", 2'd0);
        cyc();
        chk_busy("wrap3", 2'd3);
        cyc(); out_ready = 0; req = 4'b0000;
        @(negedge clk);
        chk("wd0_gnt", 8'(gnt), 8'd0);

        // Withdraw of requester 2 with ptr=0
        cyc(); req = 4'b0100;
        chk_idle("pre_wd");
        cyc();
        chk_busy("wd_sel", 2'd2);
        cyc(); req = 4'b0000;
        @(negedge clk);
        chk("wd_gnt", 8'(gnt), 8'd0);
        cyc(); req = 4'b1010;
        chk_idle("post_wd");
        // ptr still 0: requester 1 before 3
        cyc(); out_ready = 1; push(4'b0010, 2'b01); push(4'b1000, 2'b11);
        chk_busy("order1", 2'd1);
        cyc();
        chk_busy("order3", 2'd3);

        // Reset mid-transfer with out_ready high
        cyc(); rst = 1;
        chk_busy("mid_rst", 2'd1);
        chk("mid_rst_gnt", 8'(gnt), 8'd0);
        cyc(); rst = 0; req = 4'b0000; out_ready = 0;
        chk_idle("after_rst");
        chk("after_rst_sel", 8'(sel), 8'd0);

        cyc(); cyc();
        @(negedge clk);
        done = 1;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
